// File: rtl/two_comp_pipe.sv
// two_comp_pipe: pipelined two's-complement pass/negate/abs/-abs unit.
// The +1 carry ripple is split into NSTAGE = DATA_WID_/CHUNK_WID_ registered
// chunk stages. Chunk 0 is resolved in stage 0, chunk 1 in stage 1, and so on.
// Chunks that are not yet resolved travel down the pipe with the finished ones.
// Optional feature macro: TWO_COMP_SAT_EN. When it is defined, an overflowing
// result saturates to the most-positive value instead of wrapping.
//
// Handshake: valid/ready, with one global advance adv = ~out_valid | out_ready.
// in_ready = adv. Every stage register, including its valid bit, shifts only
// when adv=1. An input transfer is in_valid & in_ready. An output transfer is
// out_valid & out_ready. When in_valid=0 while adv=1, a bubble (valid=0) enters.
module two_comp_pipe #(
    parameter int DATA_WID_  = 32,
    parameter int CHUNK_WID_ = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_WID_-1:0] in_data,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_WID_-1:0] out_data,
    output logic                 out_ovf
);

    localparam int NSTAGE = DATA_WID_ / CHUNK_WID_;
    localparam logic [DATA_WID_-1:0] MOST_NEG = {1'b1, {(DATA_WID_-1){1'b0}}};

    logic                 w_adv;
    logic                 w_inv;
    logic                 w_in_ovf;
    logic [DATA_WID_-1:0] w_in_word;

    // Per-stage register outputs and the carry into each stage.
    logic [DATA_WID_-1:0] w_st_word [NSTAGE];
    logic                 w_st_vld  [NSTAGE];
    logic                 w_st_ovf  [NSTAGE];
    logic [NSTAGE-1:0]    w_cin;

    // Decide at the input whether this operand is inverted.
    always_comb begin
        w_inv = 1'b0;
        case (in_mode)
            2'b00:   w_inv = 1'b0;
            2'b01:   w_inv = 1'b1;
            2'b10:   w_inv = in_data[DATA_WID_-1];
            default: w_inv = ~in_data[DATA_WID_-1];
        endcase
    end

    // The one's complement is applied up front. The +1 ripples through the stages as carry.
    assign w_in_word = in_data ^ {DATA_WID_{w_inv}};
    assign w_in_ovf  = w_inv & (in_data == MOST_NEG);
    assign w_cin[0]  = w_inv;

    assign w_adv     = ~out_valid | out_ready;
    assign in_ready  = w_adv;

    assign out_valid = w_st_vld[NSTAGE-1];
    assign out_data  = w_st_word[NSTAGE-1];
    assign out_ovf   = w_st_ovf[NSTAGE-1];

    genvar k;
    generate
        for (k = 0; k < NSTAGE; k++) begin : g_stage
            logic [DATA_WID_-1:0]  w_prev_word;
            logic                  w_prev_vld;
            logic                  w_prev_ovf;
            logic [CHUNK_WID_-1:0] w_chunk_sum;
            logic [DATA_WID_-1:0]  w_next_word;
            logic [DATA_WID_-1:0]  w_store_word;
            logic [DATA_WID_-1:0]  r_word;
            logic                  r_vld;
            logic                  r_ovf;

            if (k == 0) begin : g_first
                assign w_prev_word = w_in_word;
                assign w_prev_vld  = in_valid;
                assign w_prev_ovf  = w_in_ovf;
            end else begin : g_follow
                assign w_prev_word = w_st_word[k-1];
                assign w_prev_vld  = w_st_vld[k-1];
                assign w_prev_ovf  = w_st_ovf[k-1];
            end

            if (k < NSTAGE - 1) begin : g_mid
                logic w_cout;
                logic r_carry;

                assign {w_cout, w_chunk_sum} =
                    {1'b0, w_prev_word[k*CHUNK_WID_ +: CHUNK_WID_]}
                    + (CHUNK_WID_+1)'(w_cin[k]);
                assign w_store_word = w_next_word;
                assign w_cin[k+1]   = r_carry;

                // Register the chunk carry-out for the next stage.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_carry <= 1'b0;
                    end else if (w_adv) begin
                        r_carry <= w_cout;
                    end
                end
            end else begin : g_last
                // The carry out of the top chunk is not needed.
                assign w_chunk_sum =
                    w_prev_word[k*CHUNK_WID_ +: CHUNK_WID_]
                    + CHUNK_WID_'(w_cin[k]);
`ifdef TWO_COMP_SAT_EN
                localparam logic [DATA_WID_-1:0] MOST_POS = {1'b0, {(DATA_WID_-1){1'b1}}};
                assign w_store_word = w_prev_ovf ? MOST_POS : w_next_word;
`else
                assign w_store_word = w_next_word;
`endif
            end

            // Put the resolved chunk k back in place. The other chunks pass through unchanged.
            always_comb begin
                w_next_word = w_prev_word;
                w_next_word[k*CHUNK_WID_ +: CHUNK_WID_] = w_chunk_sum;
            end

            // Stage register. All stages shift together on the global advance.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld  <= 1'b0;
                    r_ovf  <= 1'b0;
                    r_word <= '0;
                end else if (w_adv) begin
                    r_vld  <= w_prev_vld;
                    r_ovf  <= w_prev_ovf;
                    r_word <= w_store_word;
                end
            end

            assign w_st_word[k] = r_word;
            assign w_st_vld[k]  = r_vld;
            assign w_st_ovf[k]  = r_ovf;
        end
    endgenerate

endmodule
